// File: rtl/im_loader_if.sv
// im_loader_if: byte-stream input and BRAM port A write bundle for the loader
interface im_loader_if #(parameter int AW = 10);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [35:0]   wda;
  logic [AW-1:0] aa;
  logic          wea;
  logic          ena;
  modport master (output rx_data, rx_valid, input rx_ready, wda, aa, wea, ena);
  modport slave  (input rx_data, rx_valid, output rx_ready, wda, aa, wea, ena);
endinterface

// File: rtl/im_loader.sv
// im_loader: parses a framed byte stream and writes 36-bit words into the instruction BRAM
module im_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int          AW       = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  im_loader_if.slave bus,
  output logic       core_hold,
  output logic       load_done,
  output logic       load_err
);
  typedef enum logic [3:0] {IDLE, AH, AL, CH, CL, DATA, CSUM, DONE, ERR} state_t;
  localparam logic [16:0] MAXN = 17'(1) << AW;
  state_t        r_state;
  logic [AW-1:0] r_addr, r_aa;
  logic [15:0]   r_cnt;
  logic [2:0]    r_k;
  logic [7:0]    r_csum;
  logic [35:0]   r_word, r_wda;
  logic          r_wea, r_rdy, r_hold, r_done, r_err;
  logic          w_xfer, w_bad;
  logic [15:0]   w_n;
  assign w_xfer = bus.rx_valid & r_rdy;
  assign w_n    = {r_cnt[15:8], bus.rx_data};
  assign w_bad  = (w_n == 16'd0) || ({1'b0, w_n} > MAXN);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_aa    <= '0;
      r_cnt   <= '0;
      r_k     <= '0;
      r_csum  <= '0;
      r_word  <= '0;
      r_wda   <= '0;
      r_wea   <= 1'b0;
      r_rdy   <= 1'b0;
      r_hold  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wea  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_rdy  <= 1'b1;
      if (r_state == DONE || r_state == ERR) r_state <= IDLE;
      else if (w_xfer) begin
        if (r_state != IDLE && r_state != CSUM) r_csum <= r_csum ^ bus.rx_data;
        case (r_state)
          IDLE: if (bus.rx_data == SYNC_BYTE) begin
            r_state <= AH;
            r_csum  <= '0;
            r_hold  <= 1'b1;
          end
          AH: begin
            r_addr[AW-1:8] <= bus.rx_data[AW-9:0];
            r_state        <= AL;
          end
          AL: begin
            r_addr[7:0] <= bus.rx_data;
            r_state     <= CH;
          end
          CH: begin
            r_cnt[15:8] <= bus.rx_data;
            r_state     <= CL;
          end
          CL: begin
            r_cnt   <= w_n;
            r_k     <= '0;
            r_state <= w_bad ? ERR : DATA;
            r_err   <= w_bad;
            r_hold  <= !w_bad;
            r_rdy   <= !w_bad;
          end
          DATA: begin
            r_k    <= (r_k == 3'd4) ? 3'd0 : r_k + 3'd1;
            r_word <= (r_k == 3'd0) ? {32'b0, bus.rx_data[3:0]} : {r_word[27:0], bus.rx_data};
            if (r_k == 3'd4) begin
              r_wea   <= 1'b1;
              r_wda   <= {r_word[27:0], bus.rx_data};
              r_aa    <= r_addr;
              r_addr  <= r_addr + 1'b1;
              r_cnt   <= r_cnt - 16'd1;
              r_state <= (r_cnt == 16'd1) ? CSUM : DATA;
            end
          end
          CSUM: begin
            r_state <= (bus.rx_data == r_csum) ? DONE : ERR;
            r_done  <= (bus.rx_data == r_csum);
            r_err   <= (bus.rx_data != r_csum);
            r_hold  <= 1'b0;
            r_rdy   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
  assign bus.rx_ready = r_rdy;
  assign bus.wda      = r_wda;
  assign bus.aa       = r_aa;
  assign bus.wea      = r_wea;
  assign bus.ena      = r_wea;
  assign core_hold    = r_hold;
  assign load_done    = r_done;
  assign load_err     = r_err;
endmodule
